// File: rtl/duty_ramp_pkg.sv
// rtl/duty_ramp_pkg.sv - shared types and defaults for the duty ramp block
package duty_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } ramp_state_t;

    localparam int DEFAULT_MAX_DUTY    = 200;
    localparam int DEFAULT_STEP_CYCLES = 2400;

endpackage

// File: rtl/ramp_tick_gen.sv
// rtl/ramp_tick_gen.sv - free-running step timer with one-cycle tick at the last count
module ramp_tick_gen #(
    parameter int STEP_CYCLES = duty_ramp_pkg::DEFAULT_STEP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        tick    = 1'b0;
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == LAST) begin
                tick    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/duty_ramp.sv
// rtl/duty_ramp.sv - ramps the PWM match value toward a clamped target one step per tick
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES,
    parameter int STEP        = 1,
    parameter int MAX_DUTY    = DEFAULT_MAX_DUTY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       kill,
    input  logic [7:0] target,
    output logic [7:0] match,
    output logic       busy,
    output logic       at_target
);

    localparam logic [7:0] MAX_C  = 8'(MAX_DUTY);
    localparam logic [8:0] STEP_C = 9'(STEP);

    ramp_state_t state_q, state_d;
    logic [7:0]  match_q, match_d;
    logic        at_target_q, at_target_d;
    logic [7:0]  target_c;
    logic        tick;
    logic [8:0]  up_sum;
    logic signed [8:0] dn_diff;
    logic [7:0]  up_val, dn_val;

    ramp_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (kill | ~ena),
        .en  (ena & ~kill),
        .tick(tick)
    );

    assign target_c = (target > MAX_C) ? MAX_C : target;

    // Nine-bit arithmetic so neither direction can wrap past the clamp.
    assign up_sum  = {1'b0, match_q} + STEP_C;
    assign dn_diff = $signed({1'b0, match_q}) - $signed(STEP_C);
    assign up_val  = (up_sum > {1'b0, target_c}) ? target_c : up_sum[7:0];
    assign dn_val  = (dn_diff < $signed({1'b0, target_c})) ? target_c : dn_diff[7:0];

    always_comb begin
        match_d = match_q;
        if (kill) begin
            match_d = '0;
        end else if (ena && tick) begin
            if (target_c > match_q) begin
                match_d = up_val;
            end else if (target_c < match_q) begin
                match_d = dn_val;
            end
        end
    end

    // State and flags describe the match value they are registered alongside.
    always_comb begin
        state_d     = IDLE;
        at_target_d = ena && (match_d == target_c);
        if (!kill && ena) begin
            if (target_c > match_d) begin
                state_d = UP;
            end else if (target_c < match_d) begin
                state_d = DOWN;
            end else begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            match_q     <= '0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            at_target_q <= at_target_d;
        end
    end

    assign match     = match_q;
    assign busy      = (state_q == UP) || (state_q == DOWN);
    assign at_target = at_target_q;

endmodule
